pingpong_sram_ctrl: RTL and testbench

- Bank-state controller for the two ping-pong feature-map SRAMs between layer N (producer/writer) and layer N+1 (consumer/reader).
- Tracks each bank through EMPTY/FILLING/FULL/DRAINING and grants write and read ownership in strict alternating order.
- Generates the full/empty flags and img_request lines that drive the fetch/control stage.
- Counts completed frames and flags protocol violations.

---
 rtl/pingpong_pkg.sv | 16 +
 rtl/pingpong_bank_fsm.sv | 40 ++++
 rtl/pingpong_sram_ctrl.sv | 86 ++++++++
 tb/tb_pingpong_sram_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong feature-map SRAM bank controller.
package pingpong_pkg;
  localparam int NUM_BANKS_LOG2  = 1;
  localparam int NUM_BANKS       = 1 << NUM_BANKS_LOG2;
  localparam int FRAME_CNT_W_DEF = 16;

  localparam logic BANK1 = 1'b0;
  localparam logic BANK2 = 1'b1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;
endpackage

// File: rtl/pingpong_bank_fsm.sv
// Single-bank ownership FSM: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pingpong_bank_fsm
  import pingpong_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        grant_wr,
  input  logic        done_wr,
  input  logic        grant_rd,
  input  logic        done_rd,
  output bank_state_t state,
  output logic        full,
  output logic        empty,
  output logic        illegal
);
  bank_state_t state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_d;
  end

  // Out-of-order pulses leave the bank untouched; the top turns them into proto_err.
  always_comb begin
    state_d = state;
    unique case (state)
      EMPTY:    if (grant_wr) state_d = FILLING;
      FILLING:  if (done_wr)  state_d = FULL;
      FULL:     if (grant_rd) state_d = DRAINING;
      DRAINING: if (done_rd)  state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  assign full    = (state == FULL);
  assign empty   = (state == EMPTY);
  assign illegal = (done_wr && state != FILLING) ||
                   (done_rd && state != DRAINING) ||
                   (grant_wr && grant_rd);
endmodule

// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong SRAM bank controller: alternating write/read ownership, flags,
// completed-frame counter and sticky protocol-error flag.
module pingpong_sram_ctrl
  import pingpong_pkg::*;
#(
  parameter int FRAME_CNT_W = FRAME_CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_start,
  input  logic                   wr_done,
  input  logic                   rd_start,
  input  logic                   rd_done,
  output logic                   wr_grant,
  output logic                   wr_bank,
  output logic                   rd_grant,
  output logic                   rd_bank,
  output logic                   sram_full1,
  output logic                   sram_full2,
  output logic                   sram_empty1,
  output logic                   sram_empty2,
  output logic                   img_request1,
  output logic                   img_request2,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   proto_err
);
  logic                 wr_ptr, rd_ptr;
  bank_state_t          st [NUM_BANKS];
  logic [NUM_BANKS-1:0] full, empty, illegal;
  logic                 wr_go, rd_go, wr_fin, rd_fin;

  // A bank that is EMPTY under wr_ptr implies the writer owns nothing yet.
  assign wr_go  = wr_start && (st[wr_ptr] == EMPTY);
  assign rd_go  = rd_start && (st[rd_ptr] == FULL);
  assign wr_fin = wr_done  && (st[wr_ptr] == FILLING);
  assign rd_fin = rd_done  && (st[rd_ptr] == DRAINING);

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    pingpong_bank_fsm u_fsm (
      .clk      (clk),
      .rst      (rst),
      .grant_wr (wr_go   && (wr_ptr == 1'(gi))),
      .done_wr  (wr_done && (wr_ptr == 1'(gi))),
      .grant_rd (rd_go   && (rd_ptr == 1'(gi))),
      .done_rd  (rd_done && (rd_ptr == 1'(gi))),
      .state    (st[gi]),
      .full     (full[gi]),
      .empty    (empty[gi]),
      .illegal  (illegal[gi])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= BANK1;
      rd_ptr      <= BANK1;
      wr_grant    <= 1'b0;
      rd_grant    <= 1'b0;
      frames_done <= '0;
      proto_err   <= 1'b0;
    end else begin
      wr_grant <= wr_go;
      rd_grant <= rd_go;
      if (wr_fin) wr_ptr <= ~wr_ptr;
      if (rd_fin) begin
        rd_ptr      <= ~rd_ptr;
        frames_done <= frames_done + 1'b1;
      end
      if (|illegal) proto_err <= 1'b1;
    end
  end

  // Write needs EMPTY and read needs FULL, so both grants can never hit one bank.
  always_comb begin
    if (rst) assert (!(wr_go && rd_go && wr_ptr == rd_ptr));
  end

  assign wr_bank      = wr_ptr;
  assign rd_bank      = rd_ptr;
  assign sram_full1   = full[0];
  assign sram_full2   = full[1];
  assign sram_empty1  = empty[0];
  assign sram_empty2  = empty[1];
  assign img_request1 = empty[0] && (wr_ptr == BANK1);
  assign img_request2 = empty[1] && (wr_ptr == BANK2);
endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Directed plus randomized bench for pingpong_sram_ctrl against a bank-ownership model.
module tb_pingpong_sram_ctrl;
  logic        clk, rst;
  logic        wr_start, wr_done, rd_start, rd_done;
  logic        wr_grant, wr_bank, rd_grant, rd_bank;
  logic        sram_full1, sram_full2, sram_empty1, sram_empty2;
  logic        img_request1, img_request2;
  logic [15:0] frames_done;
  logic        proto_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model: bank codes 0=empty 1=filling 2=full 3=draining
  int mb [2];
  int mwp, mrp, mfr, merr, mwg, mrg;

  pingpong_sram_ctrl #(.FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_done(wr_done), .rd_start(rd_start), .rd_done(rd_done),
    .wr_grant(wr_grant), .wr_bank(wr_bank), .rd_grant(rd_grant), .rd_bank(rd_bank),
    .sram_full1(sram_full1), .sram_full2(sram_full2),
    .sram_empty1(sram_empty1), .sram_empty2(sram_empty2),
    .img_request1(img_request1), .img_request2(img_request2),
    .frames_done(frames_done), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mb[0] = 0; mb[1] = 0;
    mwp = 0; mrp = 0; mfr = 0; merr = 0; mwg = 0; mrg = 0;
  endtask

  // One clock edge of the ownership rules, using the inputs held at that edge.
  task automatic model_edge();
    int nb [2];
    int wp, rp;
    nb[0] = mb[0]; nb[1] = mb[1];
    wp = mwp; rp = mrp;
    mwg = (wr_start && mb[wp] == 0) ? 1 : 0;
    mrg = (rd_start && mb[rp] == 2) ? 1 : 0;
    if (mwg == 1) nb[wp] = 1;
    if (mrg == 1) nb[rp] = 3;
    if (wr_done) begin
      if (mb[wp] == 1) begin nb[wp] = 2; mwp = 1 - wp; end
      else merr = 1;
    end
    if (rd_done) begin
      if (mb[rp] == 3) begin nb[rp] = 0; mrp = 1 - rp; mfr = (mfr + 1) % 65536; end
      else merr = 1;
    end
    mb[0] = nb[0]; mb[1] = nb[1];
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_grant"}, 32'(wr_grant), 32'(mwg));
    chk({tag, ".rd_grant"}, 32'(rd_grant), 32'(mrg));
    chk({tag, ".wr_bank"}, 32'(wr_bank), 32'(mwp));
    chk({tag, ".rd_bank"}, 32'(rd_bank), 32'(mrp));
    chk({tag, ".full1"}, 32'(sram_full1), 32'(mb[0] == 2));
    chk({tag, ".full2"}, 32'(sram_full2), 32'(mb[1] == 2));
    chk({tag, ".empty1"}, 32'(sram_empty1), 32'(mb[0] == 0));
    chk({tag, ".empty2"}, 32'(sram_empty2), 32'(mb[1] == 0));
    chk({tag, ".img_req1"}, 32'(img_request1), 32'(mb[0] == 0 && mwp == 0));
    chk({tag, ".img_req2"}, 32'(img_request2), 32'(mb[1] == 0 && mwp == 1));
    chk({tag, ".frames"}, 32'(frames_done), 32'(mfr));
    chk({tag, ".proto_err"}, 32'(proto_err), 32'(merr));
  endtask

  task automatic cyc(input string tag, input logic ws, input logic wd, input logic rs, input logic rd);
    wr_start = ws; wr_done = wd; rd_start = rs; rd_done = rd;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset is asserted mid-cycle and checked before any further clock edge.
  task automatic apply_reset(input string tag);
    wr_start = 0; wr_done = 0; rd_start = 0; rd_done = 0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    wr_start = 0; wr_done = 0; rd_start = 0; rd_done = 0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.img_req1_const", 32'(img_request1), 32'd1);
    chk("reset.img_req2_const", 32'(img_request2), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    cyc("idle", 0, 0, 0, 0);
    cyc("idle_rd_held", 0, 0, 1, 0);

    // Single frame through bank1
    cyc("sf.wgrant", 1, 0, 0, 0);
    chk("sf.wr_grant_const", 32'(wr_grant), 32'd1);
    cyc("sf.fill", 0, 0, 0, 0);
    cyc("sf.fill", 0, 0, 0, 0);
    cyc("sf.fill", 0, 0, 0, 0);
    cyc("sf.wdone", 0, 1, 0, 0);
    chk("sf.full1_const", 32'(sram_full1), 32'd1);
    chk("sf.wr_bank_const", 32'(wr_bank), 32'd1);
    cyc("sf.rgrant", 0, 0, 1, 0);
    chk("sf.rd_grant_const", 32'(rd_grant), 32'd1);
    cyc("sf.rdone", 0, 0, 0, 1);
    chk("sf.frames_const", 32'(frames_done), 32'd1);
    chk("sf.empty1_const", 32'(sram_empty1), 32'd1);

    // Overlap: fill bank2 while draining bank1, both done together
    apply_reset("ov.reset");
    cyc("ov.wg1", 1, 0, 0, 0);
    cyc("ov.wd1", 0, 1, 0, 0);
    cyc("ov.both_grant", 1, 0, 1, 0);
    cyc("ov.both_done", 0, 1, 0, 1);
    cyc("ov.wg_bank1", 1, 0, 0, 0);
    chk("ov.wr_bank_const", 32'(wr_bank), 32'd0);
    chk("ov.frames_const", 32'(frames_done), 32'd1);

    // Backpressure: both banks full, writer held off until bank1 drains
    apply_reset("bp.reset");
    cyc("bp.wg1", 1, 0, 0, 0);
    cyc("bp.wd1", 1, 1, 0, 0);
    cyc("bp.wg2", 1, 0, 0, 0);
    cyc("bp.wd2", 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("bp.hold", 1, 0, 0, 0);
    chk("bp.no_grant_const", 32'(wr_grant), 32'd0);
    cyc("bp.rg", 1, 0, 1, 0);
    cyc("bp.rd", 1, 0, 0, 1);
    cyc("bp.wg_after", 1, 0, 0, 0);
    chk("bp.wg_after_const", 32'(wr_grant), 32'd1);
    chk("bp.bank_const", 32'(wr_bank), 32'd0);

    // Protocol errors are sticky and leave bank state untouched
    apply_reset("pe.reset");
    cyc("pe.bad_wdone", 0, 1, 0, 0);
    chk("pe.err_const", 32'(proto_err), 32'd1);
    cyc("pe.sticky", 0, 0, 0, 0);
    cyc("pe.bad_rdone", 0, 0, 0, 1);
    cyc("pe.normal", 1, 0, 0, 0);
    apply_reset("pe.cleared");
    chk("pe.cleared_const", 32'(proto_err), 32'd0);

    // Async reset while bank2 is filling
    cyc("ar.wg1", 1, 0, 0, 0);
    cyc("ar.wd1", 0, 1, 0, 0);
    cyc("ar.wg2", 1, 0, 0, 0);
    apply_reset("ar.midfill");
    chk("ar.full1_const", 32'(sram_full1), 32'd0);
    cyc("ar.resume", 1, 0, 0, 0);
    chk("ar.resume_bank_const", 32'(wr_bank), 32'd0);

    // Randomized traffic, mostly legal with occasional stray done pulses
    apply_reset("rnd.reset");
    for (int i = 0; i < 600; i++) begin
      logic ws, wd, rs, rd;
      ws = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      wd = (mb[mwp] == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      rd = (mb[mrp] == 3) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      cyc("rnd", ws, wd, rs, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
